// File: rtl/lsp_pkg.sv
// Shared constants and FSM encoding for the LSP root-search pipeline
// (bracket finder and downstream bisection stage).
package lsp_pkg;

  localparam int unsigned LspN        = 32;
  localparam int unsigned LspIdxW     = 8;
  localparam int unsigned LspMaxRoots = 10;
  localparam int unsigned LspCntW     = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFirst  = 3'd1,
    StScan   = 3'd2,
    StEmit   = 3'd3,
    StFinish = 3'd4
  } lsp_state_e;

endpackage

// File: rtl/lsp_bracket_finder_if.sv
// Sample stream in, bracket stream out; slave is the bracket finder itself.
interface lsp_bracket_finder_if
  import lsp_pkg::*;
#(
  parameter int unsigned N     = LspN,
  parameter int unsigned IDX_W = LspIdxW
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_val;
  logic             in_last;
  logic             br_valid;
  logic             br_ready;
  logic [IDX_W-1:0] br_idx;
  logic [N-1:0]     br_prev;
  logic [N-1:0]     br_curr;

  modport master (
    output in_valid, in_val, in_last, br_ready,
    input  in_ready, br_valid, br_idx, br_prev, br_curr
  );

  modport slave (
    input  in_valid, in_val, in_last, br_ready,
    output in_ready, br_valid, br_idx, br_prev, br_curr
  );
endinterface

// File: rtl/neg_check.sv
// Sign-change detector between two IEEE-754 words; purely bit-based, so
// +0/-0 differ and NaN sign bits are taken as-is.
module neg_check #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] psumr,
  input  logic [N-1:0] psum1,
  output logic         neg
);
  logic unused_mag;

  assign neg        = psumr[N-1] ^ psum1[N-1];
  assign unused_mag = ^{psumr[N-2:0], psum1[N-2:0]};
endmodule

// File: rtl/lsp_bracket_finder.sv
// Scans a stream of polynomial samples and emits one (idx, prev, curr)
// bracket per sign change, stopping at MAX_ROOTS brackets or end of sweep.
module lsp_bracket_finder
  import lsp_pkg::*;
#(
  parameter int unsigned N         = LspN,
  parameter int unsigned IDX_W     = LspIdxW,
  parameter int unsigned MAX_ROOTS = LspMaxRoots,
  parameter int unsigned CNT_W     = LspCntW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  lsp_bracket_finder_if.slave  bus,
  output logic [CNT_W-1:0]     root_cnt,
  output logic                 done,
  output logic                 busy
);

  lsp_state_e       state_q;
  logic             in_ready_q;
  logic             br_valid_q;
  logic             done_q;
  logic             busy_q;
  logic             last_seen_q;
  logic [IDX_W-1:0] br_idx_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     br_prev_q;
  logic [N-1:0]     br_curr_q;
  logic [N-1:0]     prev_q;
  logic [CNT_W-1:0] root_cnt_q;

  logic in_xfer;
  logic sign_change;
  logic last_root;

  neg_check #(
    .N(N)
  ) u_neg_check (
    .psumr(prev_q),
    .psum1(bus.in_val),
    .neg  (sign_change)
  );

  assign in_xfer   = bus.in_valid && in_ready_q;
  assign last_root = (root_cnt_q + CNT_W'(1)) == CNT_W'(MAX_ROOTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      br_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      last_seen_q <= 1'b0;
      br_idx_q    <= '0;
      idx_q       <= '0;
      br_prev_q   <= '0;
      br_curr_q   <= '0;
      prev_q      <= '0;
      root_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            root_cnt_q <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StFirst;
          end
        end
        StFirst: begin
          if (in_xfer) begin
            prev_q <= bus.in_val;
            idx_q  <= '0;
            if (bus.in_last) begin
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StFinish;
            end else begin
              state_q <= StScan;
            end
          end
        end
        StScan: begin
          if (in_xfer) begin
            prev_q <= bus.in_val;
            idx_q  <= idx_q + IDX_W'(1);
            // idx_q names the left sample of the pair being compared
            if (sign_change) begin
              br_idx_q    <= idx_q;
              br_prev_q   <= prev_q;
              br_curr_q   <= bus.in_val;
              last_seen_q <= bus.in_last;
              br_valid_q  <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= StEmit;
            end else if (bus.in_last) begin
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StFinish;
            end
          end
        end
        StEmit: begin
          if (bus.br_ready) begin
            br_valid_q <= 1'b0;
            root_cnt_q <= root_cnt_q + CNT_W'(1);
            if (last_root || last_seen_q) begin
              done_q  <= 1'b1;
              state_q <= StFinish;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= StScan;
            end
          end
        end
        StFinish: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          in_ready_q <= 1'b0;
          br_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.br_valid = br_valid_q;
  assign bus.br_idx   = br_idx_q;
  assign bus.br_prev  = br_prev_q;
  assign bus.br_curr  = br_curr_q;
  assign root_cnt     = root_cnt_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule
